// File: rtl/pluse_pkg.sv
// Shared constants and types for the pluse tick generator.
// Defaults assume a 100 MHz clk_sys: 100 cycles per microsecond.
package pluse_pkg;

    localparam int DIV_RST_DEF   = 99;
    localparam int US_PER_MS_DEF = 1000;
    localparam int MS_PER_S_DEF  = 1000;

    // Counter width for a modulus n. Never returns 0, so a modulus of 1 or 2
    // still gets a legal 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int US_CNT_W_DEF = cnt_w(US_PER_MS_DEF);
    localparam int MS_CNT_W_DEF = cnt_w(MS_PER_S_DEF);

    // Registered tick bundle driven by the top.
    typedef struct packed {
        logic s;
        logic ms;
        logic us;
    } pluse_t;

endpackage

// File: rtl/pluse_div_stage.sv
// One modulo counter stage of the tick chain.
// With a positive modulus the stage counts 0..MOD-1 and the lim input is ignored.
// With a zero modulus the stage counts 0..lim (used for the cycle divider).
// wrap is combinational and is high on the increment that returns the count
// to 0, so stages chain directly wrap -> inc. clr wins over inc.
module pluse_div_stage #(
    parameter int MOD = 0,
    parameter int W   = 8
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] lim,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] term;

    assign term = (MOD == 0) ? lim : W'(MOD - 1);
    assign wrap = inc && !clr && (cnt_q == term);

    // Next count: clear, wrap back to zero, or step by one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pluse_tick_gen.sv
// Microsecond / millisecond / second tick generator.
// A runtime-programmable cycle divider feeds two fixed-modulus stages; each
// stage wrap is registered into a one-cycle pulse so all three ticks are
// aligned on the same clock when they coincide. Loading a new divisor
// restarts the whole chain from zero.
module pluse_tick_gen
    import pluse_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RST   = DIV_RST_DEF,
    parameter int US_PER_MS = US_PER_MS_DEF,
    parameter int MS_PER_S  = MS_PER_S_DEF
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_us,
    output logic             pluse_us,
    output logic             pluse_ms,
    output logic             pluse_s,
    output logic [DIV_W-1:0] div_cur
);

    localparam int US_W = cnt_w(US_PER_MS);
    localparam int MS_W = cnt_w(MS_PER_S);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    pluse_t           pls_q;
    pluse_t           pls_d;

    logic inc_cyc;
    logic wrap_cyc;
    logic wrap_us;
    logic wrap_ms;

    // A load blocks counting in the same cycle; the new period starts after.
    assign inc_cyc = en && !div_load;

    pluse_div_stage #(
        .MOD (0),
        .W   (DIV_W)
    ) u_stage_cyc (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (div_load),
        .inc     (inc_cyc),
        .lim     (div_q),
        .wrap    (wrap_cyc)
    );

    pluse_div_stage #(
        .MOD (US_PER_MS),
        .W   (US_W)
    ) u_stage_us (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (div_load),
        .inc     (wrap_cyc),
        .lim     ('0),
        .wrap    (wrap_us)
    );

    pluse_div_stage #(
        .MOD (MS_PER_S),
        .W   (MS_W)
    ) u_stage_ms (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (div_load),
        .inc     (wrap_us),
        .lim     ('0),
        .wrap    (wrap_ms)
    );

    // Next divisor and tick bundle. Each wrap already implies the wrap of the
    // stage below it, so ms/s can only fire together with us.
    always_comb begin
        div_d    = div_load ? div_us : div_q;
        pls_d    = '0;
        pls_d.us = wrap_cyc;
        pls_d.ms = wrap_us;
        pls_d.s  = wrap_ms;
    end

    // Divisor and output tick registers; reset overrides load and enable.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            div_q <= DIV_W'(DIV_RST);
            pls_q <= '0;
        end else begin
            div_q <= div_d;
            pls_q <= pls_d;
        end
    end

    assign pluse_us = pls_q.us;
    assign pluse_ms = pls_q.ms;
    assign pluse_s  = pls_q.s;
    assign div_cur  = div_q;

endmodule

// File: tb/tb_pluse_tick_gen.sv
// Bench for pluse_tick_gen. The reference model counts enabled cycles since
// the last reset/load and derives every tick from divisibility by the tick
// period; directed phases pin tick spacing with literal edge counts.
module tb_pluse_tick_gen;

    localparam int DIV_W   = 8;
    localparam int DIV_RST = 99;
    localparam int US      = 4;
    localparam int MS      = 3;

    logic             clk_sys  = 1'b0;
    logic             rst_n    = 1'b0;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_us   = '0;
    logic             pluse_us;
    logic             pluse_ms;
    logic             pluse_s;
    logic [DIV_W-1:0] div_cur;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_sys = ~clk_sys;

    pluse_tick_gen #(
        .DIV_W     (DIV_W),
        .DIV_RST   (DIV_RST),
        .US_PER_MS (US),
        .MS_PER_S  (MS)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .en       (en),
        .div_load (div_load),
        .div_us   (div_us),
        .pluse_us (pluse_us),
        .pluse_ms (pluse_ms),
        .pluse_s  (pluse_s),
        .div_cur  (div_cur)
    );

    // Reference model state.
    longint m_n   = 0;
    longint m_per = 1;
    int     m_div = DIV_RST;
    bit     e_us  = 1'b0;
    bit     e_ms  = 1'b0;
    bit     e_s   = 1'b0;
    bit     chk   = 1'b0;

    // Model: tick when the enabled-cycle count hits a multiple of the period.
    always @(posedge clk_sys) begin
        if (!rst_n) begin
            m_div = DIV_RST;
            m_n   = 0;
            e_us  = 1'b0;
            e_ms  = 1'b0;
            e_s   = 1'b0;
            chk   = 1'b1;
        end else if (div_load) begin
            m_div = int'(div_us);
            m_n   = 0;
            e_us  = 1'b0;
            e_ms  = 1'b0;
            e_s   = 1'b0;
        end else if (en) begin
            m_n   = m_n + 1;
            m_per = longint'(m_div) + 1;
            e_us  = (m_n % m_per) == 0;
            e_ms  = (m_n % (m_per * US)) == 0;
            e_s   = (m_n % (m_per * US * MS)) == 0;
        end else begin
            e_us  = 1'b0;
            e_ms  = 1'b0;
            e_s   = 1'b0;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk_sys) begin
        if (chk) begin
            vectors++;
            if (pluse_us !== e_us || pluse_ms !== e_ms || pluse_s !== e_s ||
                div_cur !== m_div[DIV_W-1:0]) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t: us/ms/s/div got %b%b%b/%0d expected %b%b%b/%0d",
                         $time, pluse_us, pluse_ms, pluse_s, div_cur,
                         e_us, e_ms, e_s, m_div[DIV_W-1:0]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Edges until the selected tick (0=us 1=ms 2=s) is seen; -1 on timeout.
    task automatic wait_tick(input int which, input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_sys);
            #1;
            if ((which == 0 && pluse_us === 1'b1) ||
                (which == 1 && pluse_ms === 1'b1) ||
                (which == 2 && pluse_s  === 1'b1)) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int seen;

        // Reset state.
        step(3);
        check("rst_us", pluse_us, 0);
        check("rst_ms_s", {pluse_ms, pluse_s}, 0);
        check("rst_div_cur", div_cur, 99);

        // Default divisor: ticks at edges 100, 200, 300, ms at 400.
        rst_n = 1'b1;
        en    = 1'b1;
        wait_tick(0, 150, k);
        check("first_us_edge", k, 100);
        wait_tick(0, 150, k);
        check("second_us_gap", k, 100);
        wait_tick(0, 150, k);
        check("third_us_gap", k, 100);
        check("div_cur_default", div_cur, 99);
        step(1);
        check("us_width", pluse_us, 0);
        wait_tick(0, 150, k);
        check("fourth_us_gap", k, 99);
        check("ms_at_400", pluse_ms, 1);
        check("s_not_yet", pluse_s, 0);

        // Divisor 1: ms every 8 cycles, s every 24.
        div_load = 1'b1;
        div_us   = 8'd1;
        step(1);
        div_load = 1'b0;
        check("load1_div_cur", div_cur, 1);
        check("load1_us", pluse_us, 0);
        wait_tick(1, 50, k);
        check("ms_after_load", k, 8);
        check("ms_has_us", pluse_us, 1);
        wait_tick(2, 50, k);
        check("s_after_ms", k, 16);
        check("s_has_ms_us", {pluse_us, pluse_ms}, 2'b11);
        wait_tick(2, 50, k);
        check("s_period", k, 24);
        wait_tick(1, 50, k);
        check("ms_period", k, 8);

        // Divisor 0: us every cycle from the second cycle after load.
        div_load = 1'b1;
        div_us   = 8'd0;
        step(1);
        div_load = 1'b0;
        check("load0_div_cur", div_cur, 0);
        check("load0_us_off", pluse_us, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("div0_us_every", pluse_us, 1);
        end

        // Pause 37 cycles at count 50 with divisor 99.
        div_load = 1'b1;
        div_us   = 8'd99;
        step(1);
        div_load = 1'b0;
        step(50);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            if (pluse_us !== 1'b0) seen++;
        end
        check("pulses_while_off", seen, 0);
        en = 1'b1;
        wait_tick(0, 200, k);
        check("resume_gap", 37 + k, 87);

        // Load with enable on the edge of a scheduled wrap.
        step(99);
        div_load = 1'b1;
        div_us   = 8'd9;
        step(1);
        div_load = 1'b0;
        check("load_at_wrap_us", pluse_us, 0);
        check("load_at_wrap_div", div_cur, 9);
        wait_tick(0, 50, k);
        check("new_period", k, 10);

        // One-cycle reset mid-period at count 70.
        div_load = 1'b1;
        div_us   = 8'd149;
        step(1);
        div_load = 1'b0;
        step(70);
        rst_n = 1'b0;
        step(1);
        check("rst_mid_us", pluse_us, 0);
        check("rst_mid_div", div_cur, 99);
        rst_n = 1'b1;
        wait_tick(0, 150, k);
        check("after_rst_first", k, 100);

        en = 1'b0;
        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
